// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg
// Shared definitions for the packet arbiters: FSM state encodings, default
// sizing and a one-hot to index helper.
package axis_arb_pkg;

    localparam int DEF_N      = 4;
    localparam int DEF_DATA_W = 8;

    // Legacy-compatible state encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    // Index of the set bit in a one-hot vector of up to 8 bits
    // (returns 0 for an all-zero vector).
    function automatic int unsigned onehot_to_idx(input logic [7:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_select.sv
// rr_select
// Combinational round-robin picker. Scans req starting one past ptr and
// wrapping modulo N; the first asserted request wins.
//   req : per-source request vector
//   ptr : index of the previous winner (scan starts at ptr+1)
//   sel : one-hot winner, 0 when nothing requests
//   any : at least one request is asserted
module rr_select #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     sel,
    output logic             any
);

    always_comb begin
        int unsigned idx;
        logic        found;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[PTR_W'(idx)]) begin
                sel[PTR_W'(idx)] = 1'b1;
                found            = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter
// Packet-level round-robin arbiter merging N byte streams into one
// AXI-stream output. A source keeps the grant from its first beat until its
// last beat is captured; a one-deep registered stage drives the output.
//   clk, reset_n              : clock, asynchronous active-low reset
//   s_data/s_valid/s_last     : source beats, source i at [i*DATA_W +: DATA_W]
//   s_ready                   : per-source ready, at most one bit high
//   m_data/m_valid/m_last     : registered output beat
//   m_ready                   : downstream ready
//   grant                     : registered one-hot owner, 0 when idle
//   busy                      : a packet is locked
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N*DATA_W-1:0] s_data,
    input  logic [N-1:0]        s_valid,
    input  logic [N-1:0]        s_last,
    output logic [N-1:0]        s_ready,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_valid,
    output logic                m_last,
    input  logic                m_ready,
    output logic [N-1:0]        grant,
    output logic                busy
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [0:0]        state;
    logic [PTR_W-1:0]  ptr;
    logic [N-1:0]      sel;
    logic              any_req;
    logic              slot_free;
    logic              capture;
    logic              g_last;
    logic [DATA_W-1:0] g_data;
    logic [7:0]        grant_wide;

    rr_select #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_rr_select (
        .req (s_valid),
        .ptr (ptr),
        .sel (sel),
        .any (any_req)
    );

    // Output slot can take a beat if empty or draining this cycle
    assign slot_free = ~m_valid | m_ready;
    assign s_ready   = (state == ST_XFER && slot_free) ? grant : '0;
    assign capture   = |(s_valid & s_ready);
    assign g_last    = |(s_last & grant);
    assign busy      = (state == ST_XFER);

    // Data of the granted source (AND-OR mux over the one-hot grant)
    always_comb begin
        g_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) g_data = s_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        grant_wide         = '0;
        grant_wide[N-1:0]  = grant;
    end

    // Arbitration FSM, round-robin pointer and grant register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            grant <= '0;
            ptr   <= PTR_W'(N - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant <= sel;
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (capture && g_last) begin
                        ptr   <= PTR_W'(onehot_to_idx(grant_wide));
                        grant <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // One-deep output stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (capture) begin
            m_valid <= 1'b1;
            m_data  <= g_data;
            m_last  <= g_last;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
module tb_axis_packet_arbiter;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int NCYC = 3000;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N*DW-1:0] s_data;
    logic [N-1:0]    s_valid;
    logic [N-1:0]    s_last;
    logic [N-1:0]    s_ready;
    logic [DW-1:0]   m_data;
    logic            m_valid;
    logic            m_last;
    logic            m_ready;
    logic [N-1:0]    grant;
    logic            busy;

    always #5 clk = ~clk;

    axis_packet_arbiter #(
        .N      (N),
        .DATA_W (DW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready),
        .grant   (grant),
        .busy    (busy)
    );

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    // Reference model: per-source packet queues, expected output stream,
    // packet owner, last winner and occupancy of the output slot.
    logic [7:0]  byte_q [N][$];
    logic        last_q [N][$];
    logic [8:0]  exp_q [$];
    bit          idle;
    int unsigned owner;
    int unsigned rr_last;
    bit          slot_full;
    int unsigned force_cnt;
    int unsigned stall_cnt;
    bit          gen_on;
    bit          did_reset;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            byte_q[i].delete();
            last_q[i].delete();
        end
        exp_q.delete();
        idle      = 1'b1;
        owner     = 0;
        rr_last   = N - 1;
        slot_full = 1'b0;
    endtask

    task automatic add_packet(input int unsigned src, input int unsigned len);
        for (int unsigned j = 0; j < len; j++) begin
            byte_q[src].push_back(8'({2'(src), 6'($urandom)}));
            last_q[src].push_back(j == len - 1);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_m_valid"}, 9'(m_valid), 9'd0);
        check({tag, "_m_data"},  9'(m_data),  9'd0);
        check({tag, "_m_last"},  9'(m_last),  9'd0);
        check({tag, "_grant"},   9'(grant),   9'd0);
        check({tag, "_busy"},    9'(busy),    9'd0);
        check({tag, "_s_ready"}, 9'(s_ready), 9'd0);
    endtask

    task automatic drive();
        bit has;
        for (int i = 0; i < N; i++) begin
            has = (byte_q[i].size() != 0);
            s_valid[i] = has && (force_cnt > 0 || $urandom_range(0, 9) < 8);
            s_data[i*DW +: DW] = has ? byte_q[i][0] : 8'h00;
            s_last[i] = has ? last_q[i][0] : 1'b0;
        end
        if (force_cnt > 0) begin
            m_ready = 1'b1;
        end else if (stall_cnt > 0) begin
            m_ready = 1'b0;
            stall_cnt--;
        end else begin
            if ($urandom_range(0, 49) == 0) stall_cnt = 5;
            m_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Compare DUT against the model for this cycle, then advance the model
    // to what the upcoming clock edge should produce.
    task automatic model_step();
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_sready;
        bit           free;
        bit           accept;
        bit           found;
        bit           lst;
        int unsigned  c;

        free       = !slot_full || m_ready;
        exp_grant  = idle ? '0 : (N'(1) << owner);
        exp_sready = free ? exp_grant : '0;
        check("grant",   9'(grant),   9'(exp_grant));
        check("busy",    9'(busy),    9'(!idle));
        check("s_ready", 9'(s_ready), 9'(exp_sready));
        check("m_valid", 9'(m_valid), 9'(slot_full));

        accept = !idle && s_valid[owner] && free;
        if (accept) slot_full = 1'b1;
        else if (m_ready) slot_full = 1'b0;

        if (idle) begin
            found = 1'b0;
            for (int unsigned k = 1; k <= N; k++) begin
                c = (rr_last + k) % N;
                if (!found && s_valid[c]) begin
                    owner = c;
                    found = 1'b1;
                end
            end
            if (found) begin
                for (int j = 0; j < byte_q[owner].size(); j++)
                    exp_q.push_back({last_q[owner][j], byte_q[owner][j]});
                idle = 1'b0;
            end
        end else if (accept) begin
            lst = last_q[owner][0];
            void'(byte_q[owner].pop_front());
            void'(last_q[owner].pop_front());
            if (lst) begin
                idle    = 1'b1;
                rr_last = owner;
            end
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted output beat
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (reset_n && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL out_extra: got %h expected no beat at %0t", {m_last, m_data}, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_beat", {m_last, m_data}, e);
                end
            end
        end
    end

    initial begin
        bit all_empty;
        reset_n   = 1'b0;
        s_valid   = '0;
        s_last    = '0;
        s_data    = '0;
        m_ready   = 1'b0;
        force_cnt = 0;
        stall_cnt = 0;
        gen_on    = 1'b0;
        did_reset = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        #1 check_outputs_zero("rst");
        reset_n = 1'b1;

        // Directed opener: source 0 alone sends A1, A2, A3 (last on A3)
        byte_q[0].push_back(8'hA1); last_q[0].push_back(1'b0);
        byte_q[0].push_back(8'hA2); last_q[0].push_back(1'b0);
        byte_q[0].push_back(8'hA3); last_q[0].push_back(1'b1);
        force_cnt = 12;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (!reset_n) reset_n = 1'b1;
            if (cyc == 40) gen_on = 1'b1;
            if (gen_on) begin
                for (int unsigned i = 0; i < N; i++)
                    if (byte_q[i].size() == 0 && $urandom_range(0, 1) == 0)
                        add_packet(i, $urandom_range(1, 4));
            end
            drive();
            #1;
            if (!did_reset && cyc >= 1500 && !idle) begin
                reset_n = 1'b0;
                #1 check_outputs_zero("midrst");
                model_reset();
                did_reset = 1'b1;
                for (int unsigned i = 0; i < N; i++) add_packet(i, $urandom_range(1, 3));
                force_cnt = 6;
            end else begin
                model_step();
            end
            if (force_cnt > 0) force_cnt--;
        end

        if (!did_reset) begin
            vectors++;
            errors++;
            $display("FAIL reset_inject: got no busy cycle expected one after cycle 1500");
        end

        // Drain remaining packets with the output always ready
        gen_on = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            force_cnt = 2;
            drive();
            #1 model_step();
            all_empty = 1'b1;
            for (int i = 0; i < N; i++) if (byte_q[i].size() != 0) all_empty = 1'b0;
            if (all_empty && idle && !slot_full) break;
        end
        @(negedge clk);
        #5;
        check("drain_pending", 9'(exp_q.size()), 9'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
